register_file_sb: RTL

- Parametrised, clocked successor to the combinational-write register file: 2 read ports, 1 write port, 2^ADDRSIZE entries of WORDSIZE bits.
- Adds asynchronous reset, an optional hardwired-zero register 0 and optional write-to-read bypass.
- Adds a per-register busy scoreboard so the issue stage can reserve a destination and detect read-after-write hazards.
- Sits between decode/issue (read, reserve) and writeback (write, release).

---
 rtl/register_file_sb.sv | 80 ++++++++
 1 files changed

// File: rtl/register_file_sb.sv
// register_file_sb: 2-read/1-write register file with async reset, optional
// hardwired-zero entry 0, optional write bypass and a per-entry busy scoreboard.
module register_file_sb #(
  parameter int ADDRSIZE = 5,
  parameter int WORDSIZE = 32,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                regwr,
  input  logic [ADDRSIZE-1:0] rd,
  input  logic [WORDSIZE-1:0] rddata,
  input  logic [ADDRSIZE-1:0] rs1,
  input  logic [ADDRSIZE-1:0] rs2,
  output logic [WORDSIZE-1:0] rs1data,
  output logic [WORDSIZE-1:0] rs2data,
  output logic                rs1busy,
  output logic                rs2busy,
  input  logic                rsv,
  input  logic [ADDRSIZE-1:0] rsvrd,
  output logic                rsvok
);

  localparam int DEPTH = 1 << ADDRSIZE;
  localparam bit ZR = (ZERO_REG != 0);
  localparam bit BP = (BYPASS != 0);

  logic [WORDSIZE-1:0] mem [DEPTH];
  logic [DEPTH-1:0]    busy;

  logic                     wr_live;
  logic [1:0][ADDRSIZE-1:0] ra;
  logic [1:0][WORDSIZE-1:0] rdat;
  logic [1:0]               rbusy;
  logic                     rsv_busy;

  assign wr_live = regwr && !(ZR && rd == '0);
  assign ra[0]   = rs1;
  assign ra[1]   = rs2;

  // Later assignments take priority: bypass over storage, zero/reset over all.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      rdat[p]  = mem[ra[p]];
      rbusy[p] = busy[ra[p]];
      if (BP && wr_live && rd == ra[p]) begin
        rdat[p]  = rddata;
        rbusy[p] = 1'b0;
      end
      if (rst || (ZR && ra[p] == '0)) begin
        rdat[p]  = '0;
        rbusy[p] = 1'b0;
      end
    end
  end

  assign rs1data = rdat[0];
  assign rs2data = rdat[1];
  assign rs1busy = rbusy[0];
  assign rs2busy = rbusy[1];

  // A same-cycle release counts as free only when bypass is enabled.
  assign rsv_busy = busy[rsvrd] && !(BP && wr_live && rd == rsvrd);
  assign rsvok    = rsv && !rst && !rsv_busy && !(ZR && rsvrd == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      busy <= '0;
    end else begin
      if (wr_live) begin
        mem[rd]  <= rddata;
        busy[rd] <= 1'b0;
      end
      if (rsvok) busy[rsvrd] <= 1'b1;
    end
  end

endmodule
